// File: rtl/jt10_adpcm_rom_if.sv
// ---------------------------------------------------------------------------
// jt10_adpcm_rom_if
// External byte-wide ROM read port shared by the ADPCM-A and ADPCM-B
// channels of the YM2610 core.
//
// Signals:
//   mem_addr [24:0]  read address, bit 24 selects the region (0 = A, 1 = B)
//   mem_rd           read request, held high until acknowledged
//   mem_ok           one-cycle acknowledge, mem_din is valid in that cycle
//   mem_din  [7:0]   returned byte
//
// Modports:
//   master  the arbiter (drives address/request, receives data/ack)
//   slave   the memory  (receives address/request, drives data/ack)
// ---------------------------------------------------------------------------
interface jt10_adpcm_rom_if;
  logic [24:0] mem_addr;
  logic        mem_rd;
  logic        mem_ok;
  logic [7:0]  mem_din;

  modport master (output mem_addr, output mem_rd, input mem_ok, input mem_din);
  modport slave  (input mem_addr, input mem_rd, output mem_ok, output mem_din);
endinterface

// File: rtl/jt10_adpcm_rom.sv
// ---------------------------------------------------------------------------
// jt10_adpcm_rom
// Arbitrates the two ADPCM ROM read ports of the jt10 core onto a single
// external byte-wide memory port. The core's free-running address/roe_n
// strobes are turned into discrete read requests; the returned bytes are
// held stable for the core until the next fetch of the same channel.
// An optional one-entry tag per channel drops refetches of an address that
// was already the last completed fetch of that channel.
//
// Parameters:
//   CACHE         1 = drop triggers that hit the channel tag, 0 = always fetch
//
// Ports:
//   rst           asynchronous active-high reset
//   clk           clock, rising edge
//   adpcma_addr   ADPCM-A byte address (20 bits)
//   adpcma_bank   ADPCM-A bank (4 bits)
//   adpcma_roe_n  ADPCM-A ROM output enable, active-low
//   adpcmb_addr   ADPCM-B byte address (24 bits)
//   adpcmb_roe_n  ADPCM-B ROM output enable, active-low
//   adpcma_data   last byte fetched for channel A
//   adpcmb_data   last byte fetched for channel B
//   busy          high while a memory request is outstanding
//   mem           external memory port (master side)
// ---------------------------------------------------------------------------
module jt10_adpcm_rom #(
  parameter int CACHE = 1
) (
  input  logic                      rst,
  input  logic                      clk,
  input  logic [19:0]               adpcma_addr,
  input  logic [3:0]                adpcma_bank,
  input  logic                      adpcma_roe_n,
  input  logic [23:0]               adpcmb_addr,
  input  logic                      adpcmb_roe_n,
  output logic [7:0]                adpcma_data,
  output logic [7:0]                adpcmb_data,
  output logic                      busy,
  jt10_adpcm_rom_if.master          mem
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t      state;

  logic        cache_en;
  logic [23:0] cur_a;
  logic [23:0] prev_addr_a;
  logic [23:0] prev_addr_b;
  logic        prev_roe_n_a;
  logic        prev_roe_n_b;

  logic        pend_a;
  logic        pend_b;
  logic [23:0] tag_a;
  logic [23:0] tag_b;
  logic        tagv_a;
  logic        tagv_b;
  logic [23:0] req_tag;
  logic        owner_b;
  logic        last_b;
  logic        hold_off;

  logic        trig_a;
  logic        trig_b;
  logic        hit_a;
  logic        hit_b;
  logic        set_a;
  logic        set_b;
  logic        go;
  logic        pick_b;

  assign cache_en = (CACHE != 0);
  assign cur_a    = {adpcma_bank, adpcma_addr};

  // Trigger detection and arbitration decision.
  // A channel asks for a byte when its output enable is active and either it
  // has just become active or the address moved since the previous cycle.
  // A trigger that matches the channel tag is dropped because the data output
  // already holds that byte. When both channels are pending, the one that was
  // not served last wins, so the arbitration alternates under contention.
  // hold_off keeps the FSM in IDLE for one full cycle after every acknowledge,
  // which gives the memory side a guaranteed gap between requests.
  always_comb begin
    trig_a = ~adpcma_roe_n & (prev_roe_n_a | (cur_a != prev_addr_a));
    trig_b = ~adpcmb_roe_n & (prev_roe_n_b | (adpcmb_addr != prev_addr_b));
    hit_a  = cache_en & tagv_a & (cur_a == tag_a);
    hit_b  = cache_en & tagv_b & (adpcmb_addr == tag_b);
    set_a  = trig_a & ~hit_a;
    set_b  = trig_b & ~hit_b;
    go     = (state == IDLE) & ~hold_off & (pend_a | pend_b);
    pick_b = pend_b & (~pend_a | ~last_b);
  end

  // Main sequential block: input history, pending flags, the IDLE/BUSY FSM,
  // the memory request registers and the per-channel data/tag registers.
  // The pending flag of a channel is set by a trigger and cleared when that
  // channel is picked; if both happen on the same edge the set wins, so an
  // address that changes while its own read is in flight is fetched again
  // once the current read completes. The request address comes from the
  // registered address, i.e. the newest address the channel presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      prev_addr_a  <= 24'd0;
      prev_addr_b  <= 24'd0;
      prev_roe_n_a <= 1'b1;
      prev_roe_n_b <= 1'b1;
      pend_a       <= 1'b0;
      pend_b       <= 1'b0;
      tag_a        <= 24'd0;
      tag_b        <= 24'd0;
      tagv_a       <= 1'b0;
      tagv_b       <= 1'b0;
      req_tag      <= 24'd0;
      owner_b      <= 1'b0;
      last_b       <= 1'b1;
      hold_off     <= 1'b0;
      adpcma_data  <= 8'd0;
      adpcmb_data  <= 8'd0;
      busy         <= 1'b0;
      mem.mem_addr <= 25'd0;
      mem.mem_rd   <= 1'b0;
    end else begin
      prev_addr_a  <= cur_a;
      prev_addr_b  <= adpcmb_addr;
      prev_roe_n_a <= adpcma_roe_n;
      prev_roe_n_b <= adpcmb_roe_n;
      hold_off     <= 1'b0;

      pend_a <= set_a | (pend_a & ~(go & ~pick_b));
      pend_b <= set_b | (pend_b & ~(go & pick_b));

      case (state)
        IDLE: begin
          if (go) begin
            owner_b    <= pick_b;
            mem.mem_rd <= 1'b1;
            busy       <= 1'b1;
            state      <= BUSY;
            if (pick_b) begin
              mem.mem_addr <= {1'b1, prev_addr_b};
              req_tag      <= prev_addr_b;
            end else begin
              mem.mem_addr <= {1'b0, prev_addr_a};
              req_tag      <= prev_addr_a;
            end
          end
        end
        BUSY: begin
          if (mem.mem_ok) begin
            if (owner_b) begin
              adpcmb_data <= mem.mem_din;
              tag_b       <= req_tag;
              tagv_b      <= 1'b1;
            end else begin
              adpcma_data <= mem.mem_din;
              tag_a       <= req_tag;
              tagv_a      <= 1'b1;
            end
            last_b     <= owner_b;
            mem.mem_rd <= 1'b0;
            busy       <= 1'b0;
            hold_off   <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jt10_adpcm_rom.sv
// ---------------------------------------------------------------------------
// tb_jt10_adpcm_rom
// Directed bench for jt10_adpcm_rom. Stimulus pushes the expected reads
// (address, byte, request length) into a queue; a monitor pops an entry on
// every new mem_rd and checks address, hold time, gap and delivered data.
// A second instance with CACHE=0 shares the core-side inputs.
// ---------------------------------------------------------------------------
module tb_jt10_adpcm_rom;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    int          len;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] adpcma_addr;
  logic [3:0]  adpcma_bank;
  logic        adpcma_roe_n;
  logic [23:0] adpcmb_addr;
  logic        adpcmb_roe_n;
  logic [7:0]  adpcma_data;
  logic [7:0]  adpcmb_data;
  logic        busy;
  logic [7:0]  nc_a_data;
  logic [7:0]  nc_b_data;
  logic        nc_busy;

  jt10_adpcm_rom_if mem_if ();
  jt10_adpcm_rom_if mem_nc ();

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   wait_cycles = 0;
  bit   model_en = 1'b1;
  int   rd_count = 0;
  int   nc_count = 0;
  bit   inflight = 1'b0;

  jt10_adpcm_rom #(.CACHE(1)) dut (
    .rst          (rst),
    .clk          (clk),
    .adpcma_addr  (adpcma_addr),
    .adpcma_bank  (adpcma_bank),
    .adpcma_roe_n (adpcma_roe_n),
    .adpcmb_addr  (adpcmb_addr),
    .adpcmb_roe_n (adpcmb_roe_n),
    .adpcma_data  (adpcma_data),
    .adpcmb_data  (adpcmb_data),
    .busy         (busy),
    .mem          (mem_if)
  );

  jt10_adpcm_rom #(.CACHE(0)) dut_nc (
    .rst          (rst),
    .clk          (clk),
    .adpcma_addr  (adpcma_addr),
    .adpcma_bank  (adpcma_bank),
    .adpcma_roe_n (adpcma_roe_n),
    .adpcmb_addr  (adpcmb_addr),
    .adpcmb_roe_n (adpcmb_roe_n),
    .adpcma_data  (nc_a_data),
    .adpcmb_data  (nc_b_data),
    .busy         (nc_busy),
    .mem          (mem_nc)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [24:0] a);
    return a[7:0] ^ 8'hE0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic [24:0] a, input logic [7:0] d, input int len);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [3:0] bank, input logic [19:0] aaddr, input logic aroe,
                               input logic [23:0] baddr, input logic broe);
    @(negedge clk);
    adpcma_bank  = bank;
    adpcma_addr  = aaddr;
    adpcma_roe_n = aroe;
    adpcmb_addr  = baddr;
    adpcmb_roe_n = broe;
  endtask

  task automatic waitDrain(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || inflight || busy) && n < limit) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic waitRd(input int limit);
    int n = 0;
    while (!mem_if.mem_rd && n < limit) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("wait_mem_rd", {31'd0, mem_if.mem_rd}, 1);
  endtask

  // Memory model for the cached instance: acknowledges after wait_cycles
  // extra cycles of mem_rd, with a one-cycle mem_ok pulse.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_if.mem_ok = 1'b0;
        cnt = 0;
      end else if (model_en) begin
        if (mem_if.mem_ok) begin
          mem_if.mem_ok = 1'b0;
        end else if (mem_if.mem_rd) begin
          if (cnt >= wait_cycles) begin
            mem_if.mem_ok  = 1'b1;
            mem_if.mem_din = mem_byte(mem_if.mem_addr);
            cnt = 0;
          end else begin
            cnt++;
          end
        end
      end
    end
  end

  // Zero-wait memory for the uncached instance, plus a read counter.
  initial begin
    mem_nc.mem_ok  = 1'b0;
    mem_nc.mem_din = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) mem_nc.mem_ok = 1'b0;
      else     mem_nc.mem_ok = mem_nc.mem_rd & ~mem_nc.mem_ok;
    end
  end

  initial begin
    logic prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_nc.mem_rd && !prev && !rst) nc_count++;
      prev = mem_nc.mem_rd;
    end
  end

  // Scoreboard monitor: samples 1 unit after each rising edge.
  initial begin
    exp_t cur;
    logic prev_rd = 1'b0;
    int   edge_cnt = 0;
    int   ack_edge = 0;
    bit   have_ack = 1'b0;
    int   hold = 0;
    cur.addr = 25'd0;
    cur.data = 8'd0;
    cur.len  = 0;
    forever begin
      @(posedge clk);
      #1;
      edge_cnt++;
      if (rst) begin
        inflight = 1'b0;
        prev_rd  = 1'b0;
      end else begin
        if (mem_if.mem_rd && !prev_rd) begin
          rd_count++;
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_read_addr", {7'd0, mem_if.mem_addr}, 32'hFFFF_FFFF);
          end else begin
            cur = exp_q.pop_front();
            checkOutput("req_addr", {7'd0, mem_if.mem_addr}, {7'd0, cur.addr});
            checkOutput("req_busy", {31'd0, busy}, 1);
            if (have_ack) checkOutput("req_gap_ge2", {31'd0, (edge_cnt - ack_edge) >= 2}, 1);
            inflight = 1'b1;
            hold = 1;
          end
        end else if (mem_if.mem_rd && prev_rd && inflight) begin
          checkOutput("addr_stable", {7'd0, mem_if.mem_addr}, {7'd0, cur.addr});
          hold++;
        end
        if (mem_if.mem_ok && inflight && prev_rd) begin
          checkOutput("ack_rd_low", {31'd0, mem_if.mem_rd}, 0);
          checkOutput("ack_busy_low", {31'd0, busy}, 0);
          checkOutput("rd_hold_cycles", hold, cur.len);
          if (cur.addr[24]) checkOutput("b_data", {24'd0, adpcmb_data}, {24'd0, cur.data});
          else              checkOutput("a_data", {24'd0, adpcma_data}, {24'd0, cur.data});
          ack_edge = edge_cnt;
          have_ack = 1'b1;
          inflight = 1'b0;
        end
        prev_rd = mem_if.mem_rd;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed stimulus sequence.
  initial begin
    int rd0;
    int nc0;
    adpcma_addr    = 20'd0;
    adpcma_bank    = 4'd0;
    adpcma_roe_n   = 1'b1;
    adpcmb_addr    = 24'd0;
    adpcmb_roe_n   = 1'b1;
    mem_if.mem_ok  = 1'b0;
    mem_if.mem_din = 8'h00;

    #3;
    checkOutput("reset_mem_rd", {31'd0, mem_if.mem_rd}, 0);
    checkOutput("reset_busy", {31'd0, busy}, 0);
    checkOutput("reset_mem_addr", {7'd0, mem_if.mem_addr}, 0);
    checkOutput("reset_a_data", {24'd0, adpcma_data}, 0);
    checkOutput("reset_b_data", {24'd0, adpcmb_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] simultaneous A/B trigger, 2 wait cycles");
    wait_cycles = 2;
    pushExp(25'h0312345, 8'hA5, 3);
    pushExp(25'h1ABCDEF, 8'h0F, 3);
    applyStimulus(4'h3, 20'h12345, 1'b0, 24'hABCDEF, 1'b0);
    waitDrain(100);
    checkOutput("tie_a_hold", {24'd0, adpcma_data}, 32'hA5);
    checkOutput("tie_b_hold", {24'd0, adpcmb_data}, 32'h0F);

    $display("[TB] cached refetch of same A address");
    repeat (4) @(negedge clk);
    rd0 = rd_count;
    nc0 = nc_count;
    applyStimulus(4'h3, 20'h12345, 1'b1, 24'hABCDEF, 1'b0);
    applyStimulus(4'h3, 20'h12345, 1'b0, 24'hABCDEF, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("cache_no_read", rd_count - rd0, 0);
    checkOutput("nocache_one_read", nc_count - nc0, 1);
    checkOutput("cache_a_data", {24'd0, adpcma_data}, 32'hA5);
    checkOutput("cache_busy", {31'd0, busy}, 0);

    $display("[TB] A address change during BUSY");
    wait_cycles = 3;
    pushExp(25'h0312350, 8'hB0, 4);
    pushExp(25'h0312346, 8'hA6, 4);
    applyStimulus(4'h3, 20'h12350, 1'b0, 24'hABCDEF, 1'b0);
    waitRd(20);
    applyStimulus(4'h3, 20'h12346, 1'b0, 24'hABCDEF, 1'b0);
    waitDrain(100);
    checkOutput("busy_change_a_data", {24'd0, adpcma_data}, 32'hA6);

    $display("[TB] 100 alternating zero-wait reads");
    wait_cycles = 0;
    rd0 = rd_count;
    for (int i = 0; i < 50; i++) begin
      logic [23:0] ba;
      logic [19:0] aa;
      logic [3:0]  bk;
      ba = 24'h800000 + 24'(i * 3);
      aa = 20'h00100 + 20'(i);
      bk = 4'(i);
      pushExp({1'b1, ba}, ba[7:0] ^ 8'hE0, 1);
      pushExp({1'b0, bk, aa}, aa[7:0] ^ 8'hE0, 1);
      applyStimulus(bk, aa, 1'b0, ba, 1'b0);
      waitDrain(50);
    end
    checkOutput("alt_read_count", rd_count - rd0, 100);

    $display("[TB] reset during an outstanding read");
    wait_cycles = 5;
    pushExp(25'h0312777, 8'h97, 6);
    applyStimulus(4'h3, 20'h12777, 1'b0, adpcmb_addr, 1'b0);
    waitRd(20);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_mem_rd", {31'd0, mem_if.mem_rd}, 0);
    checkOutput("async_rst_busy", {31'd0, busy}, 0);
    checkOutput("async_rst_a_data", {24'd0, adpcma_data}, 0);
    checkOutput("async_rst_b_data", {24'd0, adpcmb_data}, 0);
    adpcma_roe_n = 1'b1;
    adpcmb_roe_n = 1'b1;
    repeat (2) @(negedge clk);
    model_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    mem_if.mem_ok  = 1'b1;
    mem_if.mem_din = 8'h77;
    @(negedge clk);
    mem_if.mem_ok  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("stray_ok_mem_rd", {31'd0, mem_if.mem_rd}, 0);
    checkOutput("stray_ok_busy", {31'd0, busy}, 0);
    checkOutput("stray_ok_a_data", {24'd0, adpcma_data}, 0);
    checkOutput("stray_ok_b_data", {24'd0, adpcmb_data}, 0);
    checkOutput("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jt10_adpcm_rom.md
# jt10_adpcm_rom

Arbitrates the YM2610 core's two ADPCM ROM read ports (ADPCM-A and ADPCM-B) onto one external byte-wide memory port with a request/acknowledge handshake. It sits directly downstream of the `jt10` address outputs and upstream of its `adpcma_data`/`adpcmb_data` inputs. It turns the core's free-running address/`roe_n` strobes into discrete memory reads and holds the returned bytes stable for the core. An optional one-entry tag per channel suppresses refetches of an unchanged address.

## Interface
Parameters:
- CACHE, 1, when 1 a trigger whose address equals that channel's last completed fetch address is dropped (no memory access); when 0 every trigger fetches.

Ports:
- rst  in  1  reset; asynchronous, active-high; clears all state.
- clk  in  1  single clock; all state changes on its rising edge.
- adpcma_addr  in  20  ADPCM-A byte address from core.
- adpcma_bank  in  4  ADPCM-A bank from core.
- adpcma_roe_n  in  1  ADPCM-A ROM output enable, active-low.
- adpcmb_addr  in  24  ADPCM-B byte address from core.
- adpcmb_roe_n  in  1  ADPCM-B ROM output enable, active-low.
- adpcma_data  out  8  last byte fetched for channel A; reset 0.
- adpcmb_data  out  8  last byte fetched for channel B; reset 0.
- mem_addr  out  25  external read address; {1'b0,bank,addr} for A, {1'b1,addr} for B; reset 0.
- mem_rd  out  1  read request, held until acknowledged; reset 0.
- mem_ok  in  1  one-cycle acknowledge; mem_din valid in the same cycle.
- mem_din  in  8  read data.
- busy  out  1  high while a request is outstanding; reset 0.

## Operation
- Per channel X∈{A,B}, registers prev_roe_n (reset 1) and prev_addr (A: 24-bit {bank,addr}; B: 24-bit; reset 0) are updated every cycle.
- A trigger fires when roe_n is 0 and either prev_roe_n is 1 or addr ≠ prev_addr.
- On a trigger, pend_X is set. The exception is CACHE=1 with tagv_X=1 and addr == tag_X, in which case the trigger is dropped.
- FSM states are IDLE and BUSY.
- In IDLE, with any pend set, the FSM selects an owner:
  - Only one channel pending: that channel is the owner.
  - Both pending: the channel ≠ last is the owner (round-robin). last resets to B, so A wins the first tie.
- On leaving IDLE:
  - mem_addr is loaded from the owner's prev_addr with the region bit.
  - mem_rd is set to 1 and busy to 1.
  - req_tag is set to that address.
  - pend_owner is cleared.
  - The state moves to BUSY.
- In BUSY, mem_addr and mem_rd are held constant. When mem_ok=1:
  - data_owner ← mem_din.
  - tag_owner ← req_tag and tagv_owner ← 1.
  - last ← owner.
  - mem_rd ← 0, busy ← 0, state → IDLE.
- If mem_ok=1 arrives in IDLE, it is ignored.
- If a trigger and a pend clear hit the same channel on the same edge, the set wins. A new address arriving during BUSY is therefore fetched after the current read completes.
- Data outputs change only on an acknowledge for their own channel. roe_n going high never clears them.
- Reset, including assertion mid-transaction, immediately forces:
  - mem_rd=0, busy=0, state IDLE.
  - All pend, tagv and data registers = 0.
  - prev_roe_n=1, last=B.
- Any late mem_ok after reset is ignored.

## Timing
- The trigger is registered: the address/roe_n presented before edge k sets pend at edge k.
- With the FSM in IDLE, mem_rd rises at edge k+1.
- The acknowledge is sampled at edge m. The data output is valid after edge m, and mem_rd is low after edge m.
- Every request returns to IDLE for at least one cycle: the next mem_rd rises no earlier than edge m+2. Back-to-back throughput is therefore at most one byte per 3 cycles with zero-wait memory (mem_ok in the first cycle of mem_rd).
- A cached hit costs no cycles; the data output is already correct.
- At most one outstanding read. Per-channel request order is preserved; only the newest address per channel is retained while pending.

## Test plan
- Reset release, then A: bank=3, addr=0x12345, roe_n falls; memory returns 0xA5 after 2 wait cycles. Required: mem_addr=0x0312345; mem_rd high 2 cycles after roe_n falls and held for 3 cycles; adpcma_data=0xA5; busy returns to 0.
- A and B trigger on the same edge, B addr=0xABCDEF. Required: A served first, then mem_addr=0x1ABCDEF; one idle cycle between the two mem_rd pulses; outputs hold their respective bytes.
- CACHE=1: A re-requests 0x0312345 (roe_n toggles high then low). Required: no mem_rd. With CACHE=0 the same stimulus issues a second read.
- During BUSY on an A read, A address changes to 0x0312346. Required: the first byte is delivered to adpcma_data, then a second read of 0x0312346 starts 2 edges after the acknowledge.
- Assert rst while mem_rd=1, then pulse mem_ok after release. Required: mem_rd and busy drop asynchronously; data outputs = 0; the stray mem_ok changes nothing.
- Continuous alternating A/B triggers with zero-wait memory for 100 reads. Required: strict A/B alternation; no lost or duplicated address; mem_addr never changes while mem_rd=1.
